uart_transmit: RTL and testbench
================================

UART_TRANSMIT -- requirements
Module: uart_transmit

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of enable ticks per serial bit.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 enable  input  1  oversample tick, one clk wide; bit timing advances only when enable=1.
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_data  input  DATA_BITS  byte to transmit; sampled only on acceptance.
REQ-008 tx_ready  output  1  high only when the block can accept a frame.
REQ-009 tx_out  output  1  serial line; idle level 1.
REQ-010 tx_busy  output  1  high while a frame is in progress.
REQ-011 tx_done  output  1  one-clk pulse at frame completion.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 Acceptance SHALL occur on a posedge where tx_valid=1 and tx_ready=1: tx_data latched into the shift register, state goes to START, sample count cleared to 0.
REQ-014 tx_ready SHALL be 1 exactly when state=IDLE and rst=0; tx_valid in any other state is ignored, with no queuing.
REQ-015 tx_out SHALL be registered: 1 in IDLE and STOP, 0 in START, shift register bit 0 in DATA; first 0 appears the cycle after acceptance.
REQ-016 Sample counter width SHALL be $clog2(OVERSAMPLE); it increments on enable=1 and wraps to 0 after OVERSAMPLE-1.
REQ-017 A bit ends on a posedge with enable=1 and count=OVERSAMPLE-1; each bit therefore lasts exactly OVERSAMPLE enable ticks.
REQ-018 At the end of START, state SHALL go to DATA with bit index 0.
REQ-019 At the end of each DATA bit, the register SHALL shift right and the index increment; after index DATA_BITS-1, state goes to STOP. Data is sent LSB first.
REQ-020 At the end of STOP, state SHALL go to IDLE and tx_done SHALL pulse for exactly one clk in the same cycle that tx_ready returns to 1.
REQ-021 A new frame SHALL be acceptable in the cycle after tx_done, giving back-to-back frames with one stop bit between them.
REQ-022 When enable=0, all counters, state and tx_out SHALL hold.
REQ-023 tx_busy SHALL equal (state != IDLE).
REQ-024 Changes on tx_data after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-025 On a posedge with rst=1, the block SHALL set: state=IDLE, count=0, bit index=0, tx_out=1, tx_busy=0, tx_done=0, tx_ready=1 on the following cycle.
REQ-026 rst SHALL override all other inputs, including tx_valid in the same cycle (no acceptance).
REQ-027 rst mid-frame SHALL abort the frame: tx_out returns to 1 at that edge and tx_done is not pulsed.

Structure
REQ-028 Package uart_pkg SHALL hold the tx state enum and the OVERSAMPLE/DATA_BITS default constants shared with the receiver.
REQ-029 The oversample counter SHALL be sub-module bit_sample_count_transmit (inputs clk, rst, enable, clear; output bit_end pulse). FSM and shift register stay in uart_transmit.

Verification
REQ-030 enable=1 every clk, send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clks; tx_done at clk 160 after acceptance.
REQ-031 enable=1 every 4th clk, send 0x3C -> each bit held 64 clks; total frame 640 clks; no state change while enable=0.
REQ-032 Back-to-back 0x00 then 0xFF with tx_valid held high -> second start bit begins the clk after tx_done; exactly one 16-tick stop bit between frames.
REQ-033 tx_valid pulsed with 0x55 during DATA of frame 0x81 -> ignored; only 0x81 is transmitted, and tx_ready stays 0.
REQ-034 rst asserted during DATA bit 3 -> tx_out=1 and tx_busy=0 the next cycle, no tx_done; the next frame 0x12 is transmitted correctly.
REQ-035 rst and tx_valid both high in the same clk -> no frame is started and tx_out remains 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and default frame constants.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int safe_clog2(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/bit_sample_count_transmit.sv
// Oversample tick counter for the transmitter: flags the last tick of each serial bit.
module bit_sample_count_transmit
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = safe_clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] count_r;

  // Count enable ticks, wrapping after the last tick of a bit; clear holds it at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r <= '0;
    end else if (enable) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  // A bit ends on the enabled tick that completes the final oversample slot.
  assign bit_end = enable & ~clear & (count_r == LAST);

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, one stop bit.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IW = safe_clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [IW-1:0]        idx_r, idx_s;
  logic                 tx_out_r, tx_out_s;
  logic                 tx_done_r, tx_done_s;
  logic                 bit_end_s;
  logic                 count_clear_s;

  // The counter sits at zero while idle so every frame starts on a fresh bit period.
  assign count_clear_s = (state_r == IDLE);

  bit_sample_count_transmit #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_count (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (count_clear_s),
    .bit_end(bit_end_s)
  );

  // State register, shift register, bit index and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      idx_r     <= '0;
      tx_out_r  <= 1'b1;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      idx_r     <= idx_s;
      tx_out_r  <= tx_out_s;
      tx_done_r <= tx_done_s;
    end
  end

  // Next-state logic; the line level is derived from the next state so tx_out is registered.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    idx_s     = idx_r;
    tx_done_s = 1'b0;
    tx_out_s  = 1'b1;

    case (state_r)
      IDLE: begin
        if (tx_valid) begin
          state_s = START;
          shift_s = tx_data;
          idx_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          idx_s   = '0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = shift_r >> 1;
          if (idx_r == LAST_IDX) begin
            state_s = STOP;
            idx_s   = '0;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_s   = IDLE;
          tx_done_s = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    case (state_s)
      IDLE:    tx_out_s = 1'b1;
      START:   tx_out_s = 1'b0;
      DATA:    tx_out_s = shift_s[0];
      STOP:    tx_out_s = 1'b1;
      default: tx_out_s = 1'b1;
    endcase
  end

  // Ready is masked by reset so a request in a reset cycle is never seen as accepted.
  assign tx_ready = (state_r == IDLE) & ~rst;
  assign tx_busy  = (state_r != IDLE);
  assign tx_out   = tx_out_r;
  assign tx_done  = tx_done_r;

endmodule

// File: tb/tb_uart_transmit.sv
// Directed self-checking bench for uart_transmit.
module tb_uart_transmit;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int checks;
  int errors;
  int cyc;
  int en_period;

  uart_transmit #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, sample point is 1 ns after the edge; enable is set up for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    enable = ((cyc % en_period) == 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one frame and check every clock of it against the expected line pattern.
  task automatic send(input string tag, input logic [7:0] data, input int bit_clks,
                      input bit keep_valid, input logic [7:0] next_data, input int inject_at);
    logic [9:0] frame;
    int         bi;
    frame = {1'b1, data, 1'b0};
    if (!tx_valid) begin
      for (int w = 0; w < 8 && !enable; w++) step();
    end
    tx_valid = 1'b1;
    tx_data  = data;
    check({tag, " ready_before"}, tx_ready, 1'b1);
    step();
    tx_valid = keep_valid;
    tx_data  = keep_valid ? next_data : ~data;
    for (int n = 0; n < 10 * bit_clks; n++) begin
      bi = n / bit_clks;
      check($sformatf("%s tx_out n=%0d", tag, n), tx_out, frame[bi]);
      check($sformatf("%s busy n=%0d", tag, n), tx_busy, 1'b1);
      check($sformatf("%s done n=%0d", tag, n), tx_done, 1'b0);
      check($sformatf("%s ready n=%0d", tag, n), tx_ready, 1'b0);
      if (n == inject_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end else if (n == inject_at + 1) begin
        tx_valid = 1'b0;
        tx_data  = ~data;
      end
      step();
    end
    check({tag, " done_pulse"}, tx_done, 1'b1);
    check({tag, " ready_after"}, tx_ready, 1'b1);
    check({tag, " busy_after"}, tx_busy, 1'b0);
    check({tag, " line_after"}, tx_out, 1'b1);
    if (!keep_valid) begin
      step();
      check({tag, " done_one_clk"}, tx_done, 1'b0);
      check({tag, " idle_line"}, tx_out, 1'b1);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    en_period = 1;
    enable    = 1'b1;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;

    // Reset state
    step();
    step();
    check("rst ready_in_reset", tx_ready, 1'b0);
    check("rst tx_out", tx_out, 1'b1);
    check("rst busy", tx_busy, 1'b0);
    check("rst done", tx_done, 1'b0);
    rst = 1'b0;
    #1;
    check("rst ready_released", tx_ready, 1'b1);

    // 0xA5 with enable every clock: 16 clks per bit, done 160 clks after acceptance
    send("a5", 8'hA5, 16, 1'b0, 8'h00, -1);

    // 0x3C with enable every 4th clock: 64 clks per bit, lines hold between ticks
    en_period = 4;
    enable    = ((cyc % en_period) == 0);
    send("3c", 8'h3C, 64, 1'b0, 8'h00, -1);
    en_period = 1;
    enable    = 1'b1;

    // Back-to-back 0x00 then 0xFF with tx_valid held: second start bit the clk after done,
    // so the line is high for the 16-clk stop bit plus the single done cycle.
    send("b2b0", 8'h00, 16, 1'b1, 8'hFF, -1);
    send("b2b1", 8'hFF, 16, 1'b0, 8'h00, -1);

    // Request of 0x55 during DATA of 0x81 is ignored
    send("81", 8'h81, 16, 1'b0, 8'h00, 53);

    // Reset during DATA bit 3 of 0xC3 aborts the frame without tx_done
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    step();
    tx_valid = 1'b0;
    check("abort start_bit", tx_out, 1'b0);
    repeat (68) step();
    check("abort bit3", tx_out, 1'b0);
    check("abort busy_mid", tx_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("abort tx_out", tx_out, 1'b1);
    check("abort busy", tx_busy, 1'b0);
    check("abort done", tx_done, 1'b0);
    check("abort ready", tx_ready, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("abort no_done k=%0d", k), tx_done, 1'b0);
      check($sformatf("abort idle k=%0d", k), tx_out, 1'b1);
    end
    send("12", 8'h12, 16, 1'b0, 8'h00, -1);

    // Reset and request in the same clock: no frame starts
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    #1;
    check("rstvalid ready", tx_ready, 1'b0);
    step();
    rst      = 1'b0;
    tx_valid = 1'b0;
    #1;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("rstvalid line k=%0d", k), tx_out, 1'b1);
      check($sformatf("rstvalid busy k=%0d", k), tx_busy, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
